md_nl_loader: RTL and testbench



---
 rtl/md_nl_loader_if.sv | 46 ++++
 rtl/md_nl_loader.sv | 202 ++++++++++++++++++++
 tb/tb_md_nl_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/md_nl_loader_if.sv
// Bundle of the host config handshake, neighbour-list write port and force-return stream
// seen by md_nl_loader.
interface md_nl_loader_if #(
    parameter int IDX_W  = 6,
    parameter int ADDR_W = 7,
    parameter int F_W    = 16
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [IDX_W-1:0]  cfg_off0;
    logic [IDX_W-1:0]  cfg_off1;
    logic [IDX_W-1:0]  cfg_off2;
    logic [IDX_W-1:0]  cfg_off3;
    logic              nl_we;
    logic [ADDR_W-1:0] nl_waddr;
    logic [IDX_W-1:0]  nl_wdata;
    logic              start;
    logic              out_we;
    logic [IDX_W-1:0]  out_addr;
    logic [F_W-1:0]    out_fx;
    logic [F_W-1:0]    out_fy;
    logic [F_W-1:0]    out_fz;
    logic              done;
    logic              busy;
    logic              run_done;
    logic [ADDR_W-1:0] beat_count;
    logic              any_nz;
    logic              seq_err;
    logic              timeout;

    // Loader side
    modport slave (
        input  cfg_valid, cfg_off0, cfg_off1, cfg_off2, cfg_off3,
        input  out_we, out_addr, out_fx, out_fy, out_fz, done,
        output cfg_ready, nl_we, nl_waddr, nl_wdata, start,
        output busy, run_done, beat_count, any_nz, seq_err, timeout
    );

    // Host / kernel side
    modport master (
        output cfg_valid, cfg_off0, cfg_off1, cfg_off2, cfg_off3,
        output out_we, out_addr, out_fx, out_fy, out_fz, done,
        input  cfg_ready, nl_we, nl_waddr, nl_wdata, start,
        input  busy, run_done, beat_count, any_nz, seq_err, timeout
    );
endinterface

// File: rtl/md_nl_loader.sv
// Host-side driver for the md_kernel: writes a periodic neighbour list from a 4-offset
// pattern, kicks the kernel, then monitors the force stream until done or timeout.
module md_nl_loader #(
    parameter int N_ATOMS = 32,
    parameter int N_NBR   = 4,
    parameter int IDX_W   = 6,
    parameter int ADDR_W  = 7,
    parameter int F_W     = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    md_nl_loader_if.slave    bus
);
    localparam int LOG_N  = $clog2(N_ATOMS);
    localparam int SLOT_W = $clog2(N_NBR);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ATOMS * N_NBR - 1);
    localparam logic [ADDR_W-1:0] BEAT_MAX  = '1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_KICK,
        S_WAIT,
        S_FIN
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  off_q [N_NBR];
    logic [IDX_W-1:0]  off_d [N_NBR];
    logic [IDX_W-1:0]  cfg_off [N_NBR];
    logic              cfg_ready_q, cfg_ready_d;
    logic              nl_we_q, nl_we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [IDX_W-1:0]  wdata_q, wdata_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              run_done_q, run_done_d;
    logic [ADDR_W-1:0] beat_count_q, beat_count_d;
    logic              any_nz_q, any_nz_d;
    logic              seq_err_q, seq_err_d;
    logic              timeout_q, timeout_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic [ADDR_W-1:0]        next_addr;
    logic [ADDR_W-SLOT_W-1:0] next_atom;
    logic [SLOT_W-1:0]        next_slot;
    logic [IDX_W-1:0]         next_off;
    logic [ADDR_W-1:0]        wrap_sum;
    logic [IDX_W-1:0]         next_data;
    logic                     beat_nz;

    assign cfg_off[0] = bus.cfg_off0;
    assign cfg_off[1] = bus.cfg_off1;
    assign cfg_off[2] = bus.cfg_off2;
    assign cfg_off[3] = bus.cfg_off3;

    // Data for the next write; in IDLE the offsets come straight from the host so the
    // first entry can be registered on the accept edge itself.
    always_comb begin
        next_addr = (state_q == S_IDLE) ? '0 : waddr_q + 1'b1;
        next_atom = next_addr[ADDR_W-1:SLOT_W];
        next_slot = next_addr[SLOT_W-1:0];
        next_off  = (state_q == S_IDLE) ? cfg_off[next_slot] : off_q[next_slot];
        wrap_sum  = {{SLOT_W{1'b0}}, next_atom}
                  + {{(ADDR_W-IDX_W){next_off[IDX_W-1]}}, next_off};
        next_data = IDX_W'(wrap_sum[LOG_N-1:0]);
        beat_nz   = (bus.out_fx != '0) || (bus.out_fy != '0) || (bus.out_fz != '0);
    end

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        cfg_ready_d  = cfg_ready_q;
        nl_we_d      = nl_we_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        start_d      = start_q;
        busy_d       = busy_q;
        run_done_d   = run_done_q;
        beat_count_d = beat_count_q;
        any_nz_d     = any_nz_q;
        seq_err_d    = seq_err_q;
        timeout_d    = timeout_q;
        wait_cnt_d   = wait_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cfg_valid) begin
                    state_d      = S_WRITE;
                    off_d        = cfg_off;
                    cfg_ready_d  = 1'b0;
                    busy_d       = 1'b1;
                    nl_we_d      = 1'b1;
                    waddr_d      = next_addr;
                    wdata_d      = next_data;
                    beat_count_d = '0;
                    any_nz_d     = 1'b0;
                    seq_err_d    = 1'b0;
                    timeout_d    = 1'b0;
                end
            end
            S_WRITE: begin
                if (waddr_q == LAST_ADDR) begin
                    state_d = S_KICK;
                    nl_we_d = 1'b0;
                    start_d = 1'b1;
                end else begin
                    waddr_d = next_addr;
                    wdata_d = next_data;
                end
            end
            S_KICK: begin
                state_d    = S_WAIT;
                start_d    = 1'b0;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                if (bus.out_we) begin
                    if (beat_count_q != BEAT_MAX) begin
                        beat_count_d = beat_count_q + 1'b1;
                    end
                    if (beat_nz) begin
                        any_nz_d = 1'b1;
                    end
                    if (ADDR_W'(bus.out_addr) != beat_count_q) begin
                        seq_err_d = 1'b1;
                    end
                end
                if (bus.done) begin
                    state_d    = S_FIN;
                    run_done_d = 1'b1;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = S_FIN;
                    run_done_d = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_FIN: begin
                state_d     = S_IDLE;
                run_done_d  = 1'b0;
                busy_d      = 1'b0;
                cfg_ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            for (int unsigned k = 0; k < N_NBR; k++) begin
                off_q[k] <= '0;
            end
            cfg_ready_q  <= 1'b1;
            nl_we_q      <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            run_done_q   <= 1'b0;
            beat_count_q <= '0;
            any_nz_q     <= 1'b0;
            seq_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            cfg_ready_q  <= cfg_ready_d;
            nl_we_q      <= nl_we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            run_done_q   <= run_done_d;
            beat_count_q <= beat_count_d;
            any_nz_q     <= any_nz_d;
            seq_err_q    <= seq_err_d;
            timeout_q    <= timeout_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign bus.cfg_ready  = cfg_ready_q;
    assign bus.nl_we      = nl_we_q;
    assign bus.nl_waddr   = waddr_q;
    assign bus.nl_wdata   = wdata_q;
    assign bus.start      = start_q;
    assign bus.busy       = busy_q;
    assign bus.run_done   = run_done_q;
    assign bus.beat_count = beat_count_q;
    assign bus.any_nz     = any_nz_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_md_nl_loader.sv
// Directed bench for md_nl_loader: neighbour-list contents, kernel handshake, status
// flags, timeout and mid-run reset.
module tb_md_nl_loader;
    localparam int TIMEOUT = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [5:0] mem [128];

    always #5 clk = ~clk;

    md_nl_loader_if #(.IDX_W(6), .ADDR_W(7), .F_W(16)) bus ();

    md_nl_loader #(
        .N_ATOMS(32), .N_NBR(4), .IDX_W(6), .ADDR_W(7), .F_W(16), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic kernel_idle();
        bus.out_we   = 1'b0;
        bus.out_addr = '0;
        bus.out_fx   = '0;
        bus.out_fy   = '0;
        bus.out_fz   = '0;
        bus.done     = 1'b0;
    endtask

    // One cycle of kernel output, driven between edges.
    task automatic beat(input logic [5:0] a, input logic [15:0] fx, input logic dn,
                        input logic we);
        bus.out_we   = we;
        bus.out_addr = a;
        bus.out_fx   = fx;
        bus.done     = dn;
        @(negedge clk);
        kernel_idle();
    endtask

    // Offer a pattern, capture the write burst, return at the negedge where start is high.
    task automatic load(input logic [5:0] o0, input logic [5:0] o1, input logic [5:0] o2,
                        input logic [5:0] o3, input logic hold);
        int n;
        int wr_cnt;
        int addr_err;
        for (int k = 0; k < 128; k++) mem[k] = '1;
        bus.cfg_off0  = o0;
        bus.cfg_off1  = o1;
        bus.cfg_off2  = o2;
        bus.cfg_off3  = o3;
        bus.cfg_valid = 1'b1;
        n = 0;
        while (!bus.cfg_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (!hold) bus.cfg_valid = 1'b0;
        check("we_after_accept", 32'(bus.nl_we), 1);
        wr_cnt   = 0;
        addr_err = 0;
        n        = 0;
        while (!bus.start && n < 300) begin
            if (bus.nl_we) begin
                if (32'(bus.nl_waddr) != wr_cnt) addr_err++;
                mem[bus.nl_waddr] = bus.nl_wdata;
                wr_cnt++;
            end
            @(negedge clk);
            n++;
        end
        check("write_cycles", 32'(n), 128);
        check("write_count", 32'(wr_cnt), 128);
        check("write_addr_seq", 32'(addr_err), 0);
        check("start_high", 32'(bus.start), 1);
        check("we_low_in_kick", 32'(bus.nl_we), 0);
    endtask

    task automatic wait_fin();
        int n;
        n = 0;
        while (!bus.run_done && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("run_done_seen", 32'(bus.run_done), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.cfg_valid = 1'b0;
        bus.cfg_off0  = '0;
        bus.cfg_off1  = '0;
        bus.cfg_off2  = '0;
        bus.cfg_off3  = '0;
        kernel_idle();
        repeat (3) @(negedge clk);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 1);
        check("rst_nl_we", 32'(bus.nl_we), 0);
        check("rst_start", 32'(bus.start), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_run_done", 32'(bus.run_done), 0);
        check("rst_addr", 32'(bus.nl_waddr), 0);
        check("rst_data", 32'(bus.nl_wdata), 0);
        check("rst_beats", 32'(bus.beat_count), 0);
        check("rst_flags", {29'd0, bus.any_nz, bus.seq_err, bus.timeout}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Run 1: +1,-1,+2,-2, clean zero-force stream
        load(6'd1, 6'h3F, 6'd2, 6'h3E, 1'b0);
        check("r1_mem0", 32'(mem[0]), 1);
        check("r1_mem1", 32'(mem[1]), 31);
        check("r1_mem2", 32'(mem[2]), 2);
        check("r1_mem3", 32'(mem[3]), 30);
        check("r1_mem127", 32'(mem[127]), 29);
        check("r1_busy", 32'(bus.busy), 1);
        beat(6'd5, 16'h0011, 1'b0, 1'b1);   // lands in KICK, must be ignored
        check("r1_start_once", 32'(bus.start), 0);
        for (int i = 0; i < 32; i++) beat(6'(i), 16'h0000, 1'b0, 1'b1);
        beat(6'd0, 16'h0000, 1'b1, 1'b0);
        wait_fin();
        check("r1_beats", 32'(bus.beat_count), 32);
        check("r1_any_nz", 32'(bus.any_nz), 0);
        check("r1_seq_err", 32'(bus.seq_err), 0);
        check("r1_timeout", 32'(bus.timeout), 0);
        check("r1_ready_fin", 32'(bus.cfg_ready), 0);
        @(negedge clk);
        check("r1_run_done_pulse", 32'(bus.run_done), 0);
        check("r1_ready_after", 32'(bus.cfg_ready), 1);
        check("r1_busy_after", 32'(bus.busy), 0);

        // Run 2: all +8, beat 7 negative fx, last beat together with done
        load(6'd8, 6'd8, 6'd8, 6'd8, 1'b0);
        check("r2_mem0", 32'(mem[0]), 8);
        check("r2_mem124", 32'(mem[124]), 7);
        @(negedge clk);
        for (int i = 0; i < 31; i++) beat(6'(i), (i == 7) ? 16'hFFFD : 16'h0000, 1'b0, 1'b1);
        beat(6'd31, 16'h0000, 1'b1, 1'b1);
        wait_fin();
        check("r2_beats", 32'(bus.beat_count), 32);
        check("r2_any_nz", 32'(bus.any_nz), 1);
        check("r2_seq_err", 32'(bus.seq_err), 0);
        @(negedge clk);

        // Run 3: address sequence 0,1,3
        load(6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
        check("r3_mem6", 32'(mem[6]), 1);
        @(negedge clk);
        beat(6'd0, 16'h0000, 1'b0, 1'b1);
        beat(6'd1, 16'h0000, 1'b0, 1'b1);
        beat(6'd3, 16'h0000, 1'b0, 1'b1);
        beat(6'd0, 16'h0000, 1'b1, 1'b0);
        wait_fin();
        check("r3_seq_err", 32'(bus.seq_err), 1);
        check("r3_beats", 32'(bus.beat_count), 3);
        check("r3_any_nz", 32'(bus.any_nz), 0);
        check("r3_timeout", 32'(bus.timeout), 0);
        @(negedge clk);

        // Run 4: no done -> timeout
        load(6'd1, 6'h3F, 6'd2, 6'h3E, 1'b0);
        n = 0;
        while (!bus.run_done && n < TIMEOUT + 100) begin
            @(negedge clk);
            n++;
        end
        check("r4_timeout_latency", 32'(n), TIMEOUT + 1);
        check("r4_timeout", 32'(bus.timeout), 1);
        check("r4_seq_err_clr", 32'(bus.seq_err), 0);
        check("r4_beats", 32'(bus.beat_count), 0);
        @(negedge clk);
        beat(6'd0, 16'h0005, 1'b1, 1'b1);
        beat(6'd1, 16'h0005, 1'b1, 1'b1);
        check("r4_late_beats", 32'(bus.beat_count), 0);
        check("r4_late_nz", 32'(bus.any_nz), 0);
        check("r4_late_timeout", 32'(bus.timeout), 1);
        check("r4_late_run_done", 32'(bus.run_done), 0);
        check("r4_late_busy", 32'(bus.busy), 0);

        // Run 5: reset in the middle of the write burst
        bus.cfg_valid = 1'b1;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        n = 0;
        while (bus.nl_waddr != 7'd50 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("r5_reached_50", 32'(bus.nl_waddr), 50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("r5_rst_we", 32'(bus.nl_we), 0);
        check("r5_rst_ready", 32'(bus.cfg_ready), 1);
        check("r5_rst_timeout", 32'(bus.timeout), 0);
        check("r5_rst_addr", 32'(bus.nl_waddr), 0);

        // Run 6: fresh accept restarts at 0; cfg_valid held through the busy period
        load(6'd2, 6'd3, 6'h3D, 6'h30, 1'b1);
        check("r6_mem0", 32'(mem[0]), 2);
        check("r6_mem3", 32'(mem[3]), 16);
        check("r6_mem126", 32'(mem[126]), 28);
        @(negedge clk);
        check("r6_no_reaccept", 32'(bus.nl_we), 0);
        beat(6'd0, 16'h0000, 1'b1, 1'b1);
        wait_fin();
        check("r6_beats", 32'(bus.beat_count), 1);
        @(negedge clk);
        check("r6_ready_idle", 32'(bus.cfg_ready), 1);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("r6_reaccept_we", 32'(bus.nl_we), 1);
        check("r6_reaccept_addr", 32'(bus.nl_waddr), 0);
        check("r6_reaccept_busy", 32'(bus.busy), 1);
        check("r6_reaccept_clr", 32'(bus.beat_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
